// File: rtl/mem_copy_dma.sv
// mem_copy_dma: block-copy master for the data RAM port.
// Alternates single-element reads and writes, src to dst, ascending.
module mem_copy_dma #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_mode,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic [1:0]        r_mode;
  logic [31:0]       r_buf;
  logic              r_err;
  logic              w_bad;
  logic [ADDR_W-1:0] w_step;

  always_comb begin
    w_bad = 1'b0;
    unique case (mode)
      2'b00:   w_bad = 1'b0;
      2'b01:   w_bad = src[0] | dst[0];
      2'b10:   w_bad = (|src[1:0]) | (|dst[1:0]);
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_step = ADDR_W'(1);
    unique case (r_mode)
      2'b01:   w_step = ADDR_W'(2);
      2'b10:   w_step = ADDR_W'(4);
      default: w_step = ADDR_W'(1);
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_bad || len == '0) w_next = S_DONE;
          else                    w_next = S_READ;
        end
      end
      S_READ: begin
        w_next = abort ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        if (abort)                    w_next = S_IDLE;
        else if (r_rem == LEN_W'(1))  w_next = S_DONE;
        else                          w_next = S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_mode  <= 2'b10;
      r_buf   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_src  <= src;
        r_dst  <= dst;
        r_rem  <= len;
        r_mode <= mode;
        r_err  <= w_bad;
      end
      if (r_state == S_READ) r_buf <= mem_rdata;
      // Pointers wrap naturally at ADDR_W bits.
      if (r_state == S_WRITE) begin
        r_src <= r_src + w_step;
        r_dst <= r_dst + w_step;
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    if (r_state == S_READ)  mem_addr = r_src;
    if (r_state == S_WRITE) mem_addr = r_dst;
  end

  assign mem_mode  = r_mode;
  assign mem_write = (r_state == S_WRITE);
  assign mem_wdata = r_buf;
  assign busy      = (r_state == S_READ) || (r_state == S_WRITE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: directed copies against a byte RAM model.
// Expected writes/done pulses are queued and checked by a monitor.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic        abort;
  logic [11:0] src;
  logic [11:0] dst;
  logic [12:0] len;
  logic [1:0]  mode;
  logic [11:0] mem_addr;
  logic [1:0]  mem_mode;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;

  mem_copy_dma dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .abort     (abort),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .mode      (mode),
    .mem_addr  (mem_addr),
    .mem_mode  (mem_mode),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [4096];
  logic        pl_we;
  logic        mem_clr;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;
  logic [11:0] a1, a2, a3;

  assign a1 = mem_addr + 12'd1;
  assign a2 = mem_addr + 12'd2;
  assign a3 = mem_addr + 12'd3;
  assign mem_rdata =
    (mem_mode == 2'b00) ? {24'h0, mem[mem_addr]} :
    (mem_mode == 2'b01) ? {16'h0, mem[a1], mem[mem_addr]} :
    {mem[a3], mem[a2], mem[a1], mem[mem_addr]};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_mode != 2'b00) mem[a1] <= mem_wdata[15:8];
      if (mem_mode == 2'b10) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic        is_done;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t q[$];

  task automatic exp_wr(input logic [11:0] a, input logic [31:0] d);
    q.push_back('{1'b0, a, d});
  endtask

  task automatic exp_done(input logic e);
    q.push_back('{1'b1, 12'h0, {31'h0, e}});
  endtask

  always @(negedge clk) begin
    if (clr_n && (mem_write || done)) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: write=%0b done=%0b addr=%0h expected none",
                 mem_write, done, mem_addr);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_kind", {63'h0, done}, {63'h0, e.is_done});
        if (!e.is_done) begin
          chk("wr_addr", {52'h0, mem_addr}, {52'h0, e.addr});
          chk("wr_data", {32'h0, mem_wdata}, {32'h0, e.data});
        end else begin
          chk("done_err", {63'h0, err}, {63'h0, e.data[0]});
        end
      end
    end
  end

  function automatic logic [31:0] rd32(input logic [11:0] a);
    return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
  endfunction

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic poke32(input logic [11:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) poke(a + 12'(i), d[8*i +: 8]);
  endtask

  task automatic issue(input logic [11:0] s, input logic [11:0] d,
                       input logic [12:0] l, input logic [1:0] m);
    @(negedge clk);
    src = s; dst = d; len = l; mode = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input string nm, input logic [11:0] s,
                     input logic [11:0] d, input logic [12:0] l,
                     input logic [1:0] m, input int eb, input int ed);
    int bc;
    int di;
    bc = 0;
    di = 0;
    issue(s, d, l, m);
    for (int i = 1; i <= 200 && di == 0; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) di = i;
    end
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(eb));
    chk({nm, "_done_cycle"}, 64'(di), 64'(ed));
  endtask

  localparam logic [50:0] RST_VAL = {12'h0, 2'b10, 1'b0, 32'h0, 3'b000};

  initial begin
    clr_n = 1'b0; start = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0; mode = 2'b00;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0; mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    chk("reset_outputs",
        {13'h0, mem_addr, mem_mode, mem_write, mem_wdata, busy, done, err},
        {13'h0, RST_VAL});
    @(negedge clk) clr_n = 1'b1;

    // Word copy
    poke32(12'h000, 32'h11111111);
    poke32(12'h004, 32'h22222222);
    poke32(12'h008, 32'h33333333);
    poke32(12'h00C, 32'h44444444);
    exp_wr(12'h100, 32'h11111111);
    exp_wr(12'h104, 32'h22222222);
    exp_wr(12'h108, 32'h33333333);
    exp_wr(12'h10C, 32'h44444444);
    exp_done(1'b0);
    run("word", 12'h000, 12'h100, 13'd4, 2'b10, 8, 9);
    chk("word_mem",
        {rd32(12'h100), rd32(12'h10C)}, {32'h11111111, 32'h44444444});
    chk("word_mem_mid",
        {rd32(12'h104), rd32(12'h108)}, {32'h22222222, 32'h33333333});

    // Byte copy with untouched neighbours
    poke(12'h001, 8'hAA);
    poke(12'h002, 8'hBB);
    poke(12'h003, 8'hCC);
    poke(12'h202, 8'h5A);
    poke(12'h206, 8'hA5);
    exp_wr(12'h203, 32'hAA);
    exp_wr(12'h204, 32'hBB);
    exp_wr(12'h205, 32'hCC);
    exp_done(1'b0);
    run("byte", 12'h001, 12'h203, 13'd3, 2'b00, 6, 7);
    chk("byte_mem",
        {24'h0, mem[12'h206], mem[12'h205], mem[12'h204], mem[12'h203], mem[12'h202]},
        {24'h0, 8'hA5, 8'hCC, 8'hBB, 8'hAA, 8'h5A});

    // Misaligned halfword rejected, then cleared by a valid len=0 start
    exp_done(1'b1);
    run("reject", 12'h003, 12'h000, 13'd1, 2'b01, 0, 1);
    @(negedge clk);
    chk("err_sticky", {63'h0, err}, 64'h1);
    exp_done(1'b1);
    run("illegal_mode", 12'h000, 12'h000, 13'd2, 2'b11, 0, 1);
    exp_done(1'b0);
    run("len0_clear", 12'h000, 12'h000, 13'd0, 2'b10, 0, 1);
    @(negedge clk);
    chk("err_cleared", {63'h0, err}, 64'h0);

    // Fill across the wrap point
    poke32(12'hFFC, 32'hDEADBEEF);
    exp_wr(12'h000, 32'hDEADBEEF);
    exp_wr(12'h004, 32'hDEADBEEF);
    exp_done(1'b0);
    run("wrap", 12'hFFC, 12'h000, 13'd2, 2'b10, 4, 5);
    chk("wrap_mem",
        {rd32(12'h004), rd32(12'h008)}, {32'hDEADBEEF, 32'h33333333});

    // Forward overlap replicates the first word
    poke32(12'h300, 32'hCAFEF00D);
    exp_wr(12'h304, 32'hCAFEF00D);
    exp_wr(12'h308, 32'hCAFEF00D);
    exp_wr(12'h30C, 32'hCAFEF00D);
    exp_done(1'b0);
    run("overlap", 12'h300, 12'h304, 13'd3, 2'b10, 6, 7);
    chk("overlap_mem",
        {rd32(12'h30C), rd32(12'h310)}, {32'hCAFEF00D, 32'h0});

    // Abort during WRITE of element 1
    exp_wr(12'h400, 32'h11111111);
    exp_wr(12'h404, 32'h22222222);
    issue(12'h100, 12'h400, 13'd4, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_write", {51'h0, mem_write, mem_addr}, {51'h0, 1'b1, 12'h404});
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_idle", {61'h0, busy, done, mem_write}, 64'h0);
    repeat (4) @(negedge clk);
    chk("abort_mem",
        {rd32(12'h404), rd32(12'h408)}, {32'h22222222, 32'h0});
    chk("abort_mem_last", {32'h0, rd32(12'h40C)}, 64'h0);

    // Reset mid-copy
    exp_wr(12'h500, 32'h11111111);
    issue(12'h100, 12'h500, 13'd4, 2'b10);
    repeat (3) @(posedge clk);
    #1 clr_n = 1'b0;
    #1;
    chk("reset_mid_copy",
        {13'h0, mem_addr, mem_mode, mem_write, mem_wdata, busy, done, err},
        {13'h0, RST_VAL});
    @(negedge clk) clr_n = 1'b1;
    chk("reset_mem",
        {rd32(12'h500), rd32(12'h504)}, {32'h11111111, 32'h0});
    exp_done(1'b0);
    run("after_reset_len0", 12'h100, 12'h600, 13'd0, 2'b10, 0, 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
